// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types, constants and BCD helpers for the seven-segment display path
package seg7_pkg;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    localparam logic [3:0]  SEG_BLANK = 4'hF;
    localparam logic [26:0] MAX_DISP  = 27'd99_999_999;
    localparam int          DIGITS    = 8;
    localparam int          ACC_W     = 4 * DIGITS;

    // Double-dabble pre-shift correction: any nibble >= 5 would exceed 9 after doubling.
    function automatic logic [ACC_W-1:0] dabble_adjust(input logic [ACC_W-1:0] acc);
        logic [ACC_W-1:0] r;
        r = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Digit 0 is never considered, so a zero value still shows a single 0.
    function automatic logic [ACC_W-1:0] blank_leading(input logic [ACC_W-1:0] digs);
        logic [ACC_W-1:0] r;
        logic             lead;
        r    = digs;
        lead = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lead && (digs[4*i +: 4] == 4'd0)) begin
                r[4*i +: 4] = SEG_BLANK;
            end else begin
                lead = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_scan_div.sv
// rtl/seg7_scan_div.sv - free-running scan-rate divider producing a one-cycle tick
module seg7_scan_div #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int             CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/seg7_display_ctrl.sv
// rtl/seg7_display_ctrl.sv - binary to 8-digit BCD converter with held digits and scan tick
module seg7_display_ctrl
    import seg7_pkg::*;
#(
    parameter int BIN_W    = 27,
    parameter int SCAN_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    input  logic             blank_lz,
    output logic             ready,
    output logic             done,
    output logic             overflow,
    output logic             scan_tick,
    output logic [3:0]       d0,
    output logic [3:0]       d1,
    output logic [3:0]       d2,
    output logic [3:0]       d3,
    output logic [3:0]       d4,
    output logic [3:0]       d5,
    output logic [3:0]       d6,
    output logic [3:0]       d7
);

    localparam int               STEP_W    = $clog2(BIN_W);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(BIN_W - 1);

    state_t            state;
    logic [BIN_W-1:0]  shreg;
    logic [ACC_W-1:0]  acc;
    logic [STEP_W-1:0] step;
    logic              ovf_pend;
    logic [ACC_W-1:0]  digs;

    logic [ACC_W-1:0]  acc_next;
    logic [BIN_W-1:0]  shreg_next;

    always_comb begin
        acc_next   = '0;
        shreg_next = '0;
        {acc_next, shreg_next} = {dabble_adjust(acc), shreg} << 1;
    end

    // Digits are committed on the edge that enters DONE so they are valid while done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ready    <= 1'b1;
            done     <= 1'b0;
            overflow <= 1'b0;
            digs     <= '0;
            shreg    <= '0;
            acc      <= '0;
            step     <= '0;
            ovf_pend <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        shreg    <= bin;
                        acc      <= '0;
                        step     <= '0;
                        ovf_pend <= (64'(bin) > 64'(MAX_DISP));
                        ready    <= 1'b0;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    acc   <= acc_next;
                    shreg <= shreg_next;
                    step  <= step + 1'b1;
                    if (step == LAST_STEP) begin
                        state <= DONE;
                        done  <= 1'b1;
                        if (ovf_pend) begin
                            overflow <= 1'b1;
                            digs     <= {DIGITS{SEG_BLANK}};
                        end else begin
                            overflow <= 1'b0;
                            digs     <= blank_lz ? blank_leading(acc_next) : acc_next;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign {d7, d6, d5, d4, d3, d2, d1, d0} = digs;

    seg7_scan_div #(
        .SCAN_DIV(SCAN_DIV)
    ) u_scan_div (
        .clk (clk),
        .rst (rst),
        .tick(scan_tick)
    );

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// tb/tb_seg7_display_ctrl.sv - scoreboard bench for seg7_display_ctrl
module tb_seg7_display_ctrl;

    localparam int BIN_W    = 27;
    localparam int SCAN_DIV = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [BIN_W-1:0] bin = '0;
    logic             blank_lz = 1'b0;
    logic             ready, done, overflow, scan_tick;
    logic [3:0]       d0, d1, d2, d3, d4, d5, d6, d7;

    seg7_display_ctrl #(
        .BIN_W   (BIN_W),
        .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin      (bin),
        .blank_lz (blank_lz),
        .ready    (ready),
        .done     (done),
        .overflow (overflow),
        .scan_tick(scan_tick),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .d4(d4), .d5(d5), .d6(d6), .d7(d7)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] digs;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          done_count = 0;
    logic        rst_seen = 1'b1;
    logic        done_prev = 1'b0;
    logic [31:0] prev_digs = '0;

    wire [31:0] digs_now = {d7, d6, d5, d4, d3, d2, d1, d0};

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: decimal digits by repeated division; blanking from decimal length.
    function automatic exp_t model(input int unsigned v, input bit blz);
        exp_t        e;
        int unsigned t;
        int          nd;
        e.cyc = 0;
        e.digs = '0;
        if (v > 99_999_999) begin
            e.digs = 32'hFFFF_FFFF;
            e.ovf  = 1'b1;
            return e;
        end
        e.ovf = 1'b0;
        t = v;
        for (int i = 0; i < 8; i++) begin
            e.digs[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        t  = v;
        nd = 1;
        while (t >= 10) begin
            t = t / 10;
            nd++;
        end
        if (blz) begin
            for (int i = nd; i < 8; i++) e.digs[4*i +: 4] = 4'hF;
        end
        return e;
    endfunction

    // Monitor: pops on every done pulse and watches digit stability in between.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                done_count++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending conversion (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("digits", digs_now, e.digs);
                    check("overflow", 32'(overflow), 32'(e.ovf));
                    check("done_latency", 32'(cyc), 32'(e.cyc));
                end
            end else if (!rst_seen) begin
                check("digits_stable", digs_now, prev_digs);
            end
            if (done_prev) check("ready_after_done", 32'(ready), 32'd1);
        end
        prev_digs = digs_now;
        done_prev = done;
    end

    task automatic do_conv(input logic [BIN_W-1:0] v, input bit blz, input bit poke);
        exp_t e;
        int   w;
        w = 0;
        while (!ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready=0 expected 1 within 200 cycles");
            return;
        end
        start    = 1'b1;
        bin      = v;
        blank_lz = blz;
        e        = model(32'(v), blz);
        e.cyc    = cyc + BIN_W + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        bin   = BIN_W'($urandom);
        check("ready_low_in_conv", 32'(ready), 32'd0);
        if (poke) begin
            repeat (3) begin
                repeat (4) @(negedge clk);
                start = 1'b1;
                bin   = BIN_W'($urandom);
                @(negedge clk);
                start = 1'b0;
            end
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned v;
        int          dc;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_done", 32'(done), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_scan_tick", 32'(scan_tick), 32'd0);
        check("reset_digits", digs_now, 32'd0);

        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            check("scan_tick", 32'(scan_tick), 32'((k % SCAN_DIV) == 0));
            @(negedge clk);
        end

        do_conv(27'd12345678, 1'b0, 1'b0);
        do_conv(27'd42, 1'b1, 1'b0);
        do_conv(27'd0, 1'b1, 1'b0);
        do_conv(27'd100_000_000, 1'b0, 1'b0);
        do_conv(27'd7, 1'b0, 1'b0);
        do_conv(27'd99_999_999, 1'b1, 1'b0);
        do_conv(27'd10_000_000, 1'b1, 1'b0);
        do_conv(27'd134_217_727, 1'b1, 1'b0);
        do_conv(27'd5555, 1'b1, 1'b1);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: v = $urandom_range(0, 999);
                1: v = $urandom_range(0, 99_999_999);
                2: v = $urandom_range(100_000_000, 134_217_727);
                default: v = $urandom_range(0, 9) * 10_000_000;
            endcase
            do_conv(BIN_W'(v), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain();

        do_conv(27'd100_000_000, 1'b0, 1'b0);
        drain();
        start = 1'b1;
        bin   = 27'd8765;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        dc  = done_count;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        check("abort_overflow", 32'(overflow), 32'd0);
        check("abort_digits", digs_now, 32'd0);
        repeat (40) @(negedge clk);
        check("abort_no_done", 32'(done_count - dc), 32'd0);

        dc    = done_count;
        rst   = 1'b1;
        start = 1'b1;
        bin   = 27'd99;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst_beats_start_ready", 32'(ready), 32'd1);
        repeat (35) @(negedge clk);
        check("rst_beats_start_no_done", 32'(done_count - dc), 32'd0);

        do_conv(27'd31, 1'b1, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
